// File: rtl/branch_control_unit.sv
// Registered branch resolution: flag register, condition evaluation,
// return-address stack and one-cycle-late redirect to fetch.
module branch_control_unit #(
  parameter int PC_WIDTH     = 32,
  parameter int OPCODE_WIDTH = 6,
  parameter int RAS_DEPTH    = 4,
  parameter int PC_INC       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instrValid,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic [PC_WIDTH-1:0]     branchTarget,
  input  logic                    flagWrite,
  input  logic                    signIn,
  input  logic                    carryIn,
  input  logic                    zeroIn,
  output logic                    validJump,
  output logic [PC_WIDTH-1:0]     targetPC,
  output logic                    flush,
  output logic                    rasError,
  output logic [2:0]              flags
);

  localparam int PW = $clog2(RAS_DEPTH);

  localparam logic [OPCODE_WIDTH-1:0] OP_BR   = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BZ   = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNZ  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_BCY  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNCY = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLTZ = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGTZ = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_CALL = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OP_RET  = OPCODE_WIDTH'(15);

  logic [PC_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]       top;
  logic [PW:0]         count;
  logic                sgn;
  logic                cy;
  logic                zf;
  logic                taken;
  logic                push;
  logic                pop;
  logic                retErr;
  logic                rasEmpty;
  logic                rasFull;
  logic [PW-1:0]       topNext;

  assign sgn      = flags[2];
  assign cy       = flags[1];
  assign zf       = flags[0];
  assign rasEmpty = (count == '0);
  assign rasFull  = (count == (PW+1)'(RAS_DEPTH));
  assign topNext  = top + PW'(1);

  // Conditions see the flag register as it stood before this edge.
  always_comb begin
    taken  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    retErr = 1'b0;
    if (instrValid) begin
      unique case (1'b1)
        opcode == OP_BR:   taken = 1'b1;
        opcode == OP_BZ:   taken = zf;
        opcode == OP_BNZ:  taken = !zf;
        opcode == OP_BCY:  taken = cy;
        opcode == OP_BNCY: taken = !cy;
        opcode == OP_BLTZ: taken = sgn;
        opcode == OP_BGTZ: taken = !sgn && !zf;
        opcode == OP_CALL: begin
          taken = 1'b1;
          push  = 1'b1;
        end
        opcode == OP_RET: begin
          taken  = !rasEmpty;
          pop    = !rasEmpty;
          retErr = rasEmpty;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags     <= 3'b000;
      validJump <= 1'b0;
      flush     <= 1'b0;
      rasError  <= 1'b0;
      targetPC  <= '0;
    end else begin
      validJump <= taken;
      flush     <= taken;
      rasError  <= retErr;
      if (taken) targetPC <= pop ? ras[top] : branchTarget;
      if (flagWrite) flags <= {signIn, carryIn, zeroIn};
    end
  end

  // Circular stack: a call on a full stack silently overwrites the oldest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else if (push) begin
      top          <= topNext;
      ras[topNext] <= pc + PC_WIDTH'(PC_INC);
      if (!rasFull) count <= count + (PW+1)'(1);
    end else if (pop) begin
      top   <= top - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: tb/tb_branch_control_unit.sv
// Scoreboard bench for branch_control_unit: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_branch_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instrValid;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] branchTarget;
  logic        flagWrite;
  logic        signIn;
  logic        carryIn;
  logic        zeroIn;
  logic        validJump;
  logic [31:0] targetPC;
  logic        flush;
  logic        rasError;
  logic [2:0]  flags;

  branch_control_unit #(
    .PC_WIDTH(32), .OPCODE_WIDTH(6), .RAS_DEPTH(4), .PC_INC(4)
  ) dut (
    .clk(clk), .rst(rst), .instrValid(instrValid), .opcode(opcode),
    .pc(pc), .branchTarget(branchTarget), .flagWrite(flagWrite),
    .signIn(signIn), .carryIn(carryIn), .zeroIn(zeroIn),
    .validJump(validJump), .targetPC(targetPC), .flush(flush),
    .rasError(rasError), .flags(flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // {taken, rasError, targetPC, flags}
  logic [36:0] sb [$];

  // Reference state
  bit          m_s, m_c, m_z;
  logic [31:0] m_tgt;
  logic [31:0] m_ras [$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_s = 0; m_c = 0; m_z = 0;
    m_tgt = 32'h0;
    m_ras.delete();
  endtask

  task automatic idle_inputs();
    instrValid = 0; opcode = 6'h0; pc = 32'h0; branchTarget = 32'h0;
    flagWrite = 0; signIn = 0; carryIn = 0; zeroIn = 0;
  endtask

  task automatic issue(input bit v, input logic [5:0] op,
                       input logic [31:0] p, input logic [31:0] bt,
                       input bit fw, input logic [2:0] f);
    bit tk, er;
    @(negedge clk);
    instrValid = v; opcode = op; pc = p; branchTarget = bt;
    flagWrite = fw; {signIn, carryIn, zeroIn} = f;
    tk = 0; er = 0;
    if (v) begin
      case (op)
        6'd7:  tk = 1;
        6'd8:  tk = m_z;
        6'd9:  tk = !m_z;
        6'd10: tk = m_c;
        6'd11: tk = !m_c;
        6'd12: tk = m_s;
        6'd13: tk = !m_s && !m_z;
        6'd14: begin
          tk = 1;
          m_ras.push_back(p + 32'd4);
          if (m_ras.size() > 4) m_ras.delete(0);
        end
        6'd15: begin
          if (m_ras.size() > 0) begin
            tk = 1;
            m_tgt = m_ras.pop_back();
          end else er = 1;
        end
        default: ;
      endcase
    end
    if (tk && op != 6'd15) m_tgt = bt;
    if (fw) {m_s, m_c, m_z} = f;
    sb.push_back({tk, er, m_tgt, m_s, m_c, m_z});
  endtask

  // Assert reset asynchronously mid-cycle and check the immediate clear.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("rst_validJump", {31'b0, validJump}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_rasError", {31'b0, rasError}, 32'h0);
    check("rst_targetPC", targetPC, 32'h0);
    check("rst_flags", {29'b0, flags}, 32'h0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  // Monitor: one scoreboard entry per issued cycle, compared after the edge.
  initial begin
    logic [36:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("validJump", {31'b0, validJump}, {31'b0, e[36]});
        check("flush", {31'b0, flush}, {31'b0, e[36]});
        check("rasError", {31'b0, rasError}, {31'b0, e[35]});
        check("targetPC", targetPC, e[34:3]);
        check("flags", {29'b0, flags}, {29'b0, e[2:0]});
      end
    end
  end

  initial begin
    bit v, fw;
    logic [5:0] op;
    int wait_cnt;
    idle_inputs();
    model_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;

    // 1: preload flags 111, reset, then bz not taken
    issue(0, 6'd0, 32'h0, 32'h0, 1, 3'b111);
    async_reset();
    issue(1, 6'd8, 32'h0, 32'h100, 0, 3'b000);

    // 2: zero=1, bz taken, bnz not taken
    issue(0, 6'd0, 32'h0, 32'h0, 1, 3'b001);
    issue(1, 6'd8, 32'h0, 32'h40, 0, 3'b000);
    issue(1, 6'd9, 32'h0, 32'h80, 0, 3'b000);

    // 3: same-cycle flag write is not forwarded
    issue(0, 6'd0, 32'h0, 32'h0, 1, 3'b000);
    issue(1, 6'd8, 32'h0, 32'h111, 1, 3'b001);
    issue(1, 6'd8, 32'h0, 32'h222, 0, 3'b000);

    // 4: sign=0 carry=1 zero=0 sweep
    issue(0, 6'd0, 32'h0, 32'h0, 1, 3'b010);
    issue(1, 6'd13, 32'h0, 32'h300, 0, 3'b000);
    issue(1, 6'd12, 32'h0, 32'h304, 0, 3'b000);
    issue(1, 6'd10, 32'h0, 32'h308, 0, 3'b000);
    issue(1, 6'd11, 32'h0, 32'h30c, 0, 3'b000);
    issue(1, 6'd7, 32'h0, 32'h310, 0, 3'b000);

    // 5: five calls overflow depth 4, four rets, then underflow
    for (int i = 1; i <= 5; i++)
      issue(1, 6'd14, 32'(i * 16), 32'h1000, 0, 3'b000);
    for (int i = 0; i < 5; i++)
      issue(1, 6'd15, 32'h0, 32'hdead, 0, 3'b000);

    // 6: reset right after a taken br's result, RAS cleared
    issue(1, 6'd14, 32'h500, 32'h600, 0, 3'b000);
    issue(1, 6'd7, 32'h0, 32'h700, 0, 3'b000);
    async_reset();
    issue(1, 6'd15, 32'h0, 32'h0, 0, 3'b000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 7) != 0);
      fw = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
      else op = 6'($urandom_range(7, 15));
      issue(v, op, $urandom, $urandom, fw, 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    idle_inputs();
    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
